// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline MEM stage; waits for the data-memory response, buffers it
//            under WB back-pressure, and extracts and extends load data.
// Revision : 1.0
// ============================================================================
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_to_MEM_valid,
  output logic        MEM_allow_in,
  input  logic [74:0] to_MEM_data,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        MEM_to_WB_valid,
  input  logic        WB_allow_in,
  output logic [69:0] to_WB_data,
  output logic [37:0] MEM_forward
);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_READY = 2'd2;

  logic [1:0]  r_state;
  logic        r_rbuf_valid;
  logic [31:0] r_rbuf_data;

  logic [31:0] r_pc;
  logic [4:0]  r_dest;
  logic [31:0] r_alu_result;
  logic        r_gr_we;
  logic        r_res_from_mem;
  logic [2:0]  r_mem_op;
  logic        r_mem_access;

  logic        w_mem_valid;
  logic        w_ready_go;
  logic        w_accept;
  logic        w_handoff;
  logic [31:0] w_load_src;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;
  logic [31:0] w_final_result;

  assign w_mem_valid     = (r_state != c_EMPTY);
  assign w_ready_go      = !r_mem_access | data_sram_data_ok | r_rbuf_valid;
  assign MEM_allow_in    = !w_mem_valid | (w_ready_go & WB_allow_in);
  assign MEM_to_WB_valid = w_mem_valid & w_ready_go;
  assign w_accept        = EX_to_MEM_valid & MEM_allow_in;
  assign w_handoff       = MEM_to_WB_valid & WB_allow_in;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pc           <= to_MEM_data[74:43];
      r_dest         <= to_MEM_data[42:38];
      r_alu_result   <= to_MEM_data[37:6];
      r_gr_we        <= to_MEM_data[5];
      r_res_from_mem <= to_MEM_data[4];
      r_mem_op       <= to_MEM_data[3:1];
      r_mem_access   <= to_MEM_data[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_EMPTY;
    end else if (MEM_allow_in) begin
      if (EX_to_MEM_valid)
        r_state <= to_MEM_data[0] ? c_WAIT : c_READY;
      else
        r_state <= c_EMPTY;
    end else if ((r_state == c_WAIT) && data_sram_data_ok) begin
      r_state <= c_READY;
    end
  end

  // Only a response for the instruction actually waiting may fill the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rbuf_valid <= 1'b0;
    end else if (w_handoff) begin
      r_rbuf_valid <= 1'b0;
    end else if ((r_state == c_WAIT) && r_mem_access && data_sram_data_ok) begin
      r_rbuf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_handoff && (r_state == c_WAIT) && data_sram_data_ok)
      r_rbuf_data <= data_sram_rdata;
  end

  assign w_load_src = r_rbuf_valid ? r_rbuf_data : data_sram_rdata;

  always_comb begin
    w_byte = w_load_src[7:0];
    case (r_alu_result[1:0])
      2'b00:   w_byte = w_load_src[7:0];
      2'b01:   w_byte = w_load_src[15:8];
      2'b10:   w_byte = w_load_src[23:16];
      default: w_byte = w_load_src[31:24];
    endcase
  end

  assign w_half = r_alu_result[1] ? w_load_src[31:16] : w_load_src[15:0];

  always_comb begin
    w_load_val = w_load_src;
    case (r_mem_op)
      3'b001:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b010:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b011:  w_load_val = {24'd0, w_byte};
      3'b100:  w_load_val = {16'd0, w_half};
      default: w_load_val = w_load_src;
    endcase
  end

  assign w_final_result = r_res_from_mem ? w_load_val : r_alu_result;

  assign to_WB_data  = {r_pc, r_dest, w_final_result, r_gr_we};
  assign MEM_forward = {w_mem_valid & r_res_from_mem & !w_ready_go,
                        r_dest & {5{w_mem_valid}},
                        w_final_result};

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  clock; all state updates on posedge clk.
REQ-002 reset  in  1  reset, synchronous, active-high.
REQ-003 EX_to_MEM_valid  in  1  upstream (EX) holds a valid instruction.
REQ-004 MEM_allow_in  out  1  MEM accepts a new instruction this cycle.
REQ-005 to_MEM_data  in  75  MSB-first {pc[32], dest[5], alu_result[32], gr_we[1], res_from_mem[1], mem_op[3], mem_access[1]}.
REQ-006 data_sram_data_ok  in  1  data memory response for the request EX issued, one pulse per access.
REQ-007 data_sram_rdata  in  32  response read data; valid only while data_sram_data_ok=1.
REQ-008 MEM_to_WB_valid  out  1  MEM offers a completed instruction to WB.
REQ-009 WB_allow_in  in  1  WB accepts this cycle.
REQ-010 to_WB_data  out  70  MSB-first {pc[32], dest[5], final_result[32], gr_we[1]}.
REQ-011 MEM_forward  out  38  {load_busy[1], MEM_dest[5], final_result[32]} for ID hazard logic.

Function
REQ-012 The block SHALL register to_MEM_data when EX_to_MEM_valid && MEM_allow_in, and SHALL hold it otherwise.
REQ-013 When MEM_allow_in=1, MEM_valid SHALL be loaded with EX_to_MEM_valid on the next edge.
REQ-014 States: EMPTY (MEM_valid=0), WAIT (valid, mem_access=1, no response yet), READY (valid, non-memory op or response received).
REQ-015 Transitions: EMPTY->WAIT/READY on accept; WAIT->READY on data_ok; READY->EMPTY on handoff with no new accept; READY->WAIT/READY on handoff plus same-cycle accept.
REQ-016 ready_go SHALL equal !mem_access | data_sram_data_ok | rbuf_valid.
REQ-017 MEM_allow_in SHALL equal !MEM_valid | (ready_go & WB_allow_in); MEM_to_WB_valid SHALL equal MEM_valid & ready_go.
REQ-018 If data_ok arrives while WB_allow_in=0, data_sram_rdata SHALL be captured in rbuf and rbuf_valid set the next cycle.
REQ-019 rbuf_valid SHALL clear on the edge where the instruction is handed to WB, and SHALL never be set by a data_ok while MEM_valid=0 or mem_access=0 (stray response ignored).
REQ-020 Load data source SHALL be rbuf when rbuf_valid=1, else data_sram_rdata.
REQ-021 mem_op: 000 ld.w; 001 ld.b; 010 ld.h; 011 ld.bu; 100 ld.hu; 101-111 treated as ld.w.
REQ-022 Byte select by alu_result[1:0] (00 -> bits 7:0 ... 11 -> bits 31:24); half select by alu_result[1] (0 -> 15:0, 1 -> 31:16); alu_result[0] ignored for halves; b/h sign-extend, bu/hu zero-extend to 32 bits.
REQ-023 final_result SHALL be the extracted load value when res_from_mem=1, else alu_result.
REQ-024 Stores (mem_access=1, res_from_mem=0) SHALL wait for data_ok like loads and forward gr_we unchanged.
REQ-025 MEM_dest SHALL equal dest & {5{MEM_valid}}; load_busy SHALL equal MEM_valid & res_from_mem & !ready_go.
REQ-026 to_WB_data SHALL be combinational from registered payload and current load data; 0 added latency for non-memory ops.

Reset
REQ-027 With reset=1 at an edge: MEM_valid=0, rbuf_valid=0, state EMPTY; thus MEM_to_WB_valid=0, MEM_allow_in=1, MEM_forward[37:32]=0.
REQ-028 Reset SHALL override any same-cycle accept, data_ok or handoff; payload registers need no reset.
REQ-029 Reset mid-WAIT SHALL discard the instruction; a later stray data_ok SHALL be ignored per REQ-019.

Verification
REQ-030 ALU op pc=0x1C000000, dest=5, alu_result=0x12345678, gr_we=1, mem_access=0, WB_allow_in=1 -> next cycle MEM_to_WB_valid=1, to_WB_data={0x1C000000,5,0x12345678,1}.
REQ-031 ld.b, alu_result=...03, rdata=0x80FF7F01 with data_ok two cycles after accept -> load_busy=1 and MEM_allow_in=0 while waiting; final_result=0xFFFFFF80 on the data_ok cycle.
REQ-032 ld.hu, addr[1]=1, rdata=0x8001ABCD with data_ok while WB_allow_in=0 -> rbuf captures; WB_allow_in=1 three cycles later -> final_result=0x00008001, rbuf_valid cleared after handoff.
REQ-033 Back-to-back ALU ops each cycle with WB_allow_in=1 -> one handoff per cycle, no bubble, MEM_allow_in held 1.
REQ-034 Reset asserted in WAIT, then data_ok pulse after release -> MEM_to_WB_valid stays 0, rbuf_valid stays 0.
REQ-035 Store with gr_we=0 -> blocks until data_ok, then hands off with gr_we=0 and MEM_dest=dest.
